// File: rtl/random_number_gen_pkg.sv
// Shared constants and helpers for the multi-channel pseudo-random value source.
package random_pkg;

    localparam logic        MODE_COUNT   = 1'b0;
    localparam logic        MODE_LFSR    = 1'b1;
    localparam logic [15:0] DEFAULT_POLY = 16'hB400;
    localparam logic [15:0] SEED_SPREAD  = 16'h9E37;

    // Per-channel seed before truncation; decorrelates channels sharing one base seed.
    function automatic logic [63:0] channel_seed(input logic [63:0] base, input int unsigned ch);
        return base ^ (64'(ch) * {48'h0000_0000_0000, SEED_SPREAD});
    endfunction

endpackage

// File: rtl/random_number_gen_lfsr_channel.sv
// One generator channel: Galois LFSR / wrap counter, range reduction, output register
// with valid/ack handshake and sticky overrun.
module lfsr_channel
    import random_pkg::*;
#(
    parameter int unsigned           OUT_WIDTH  = 9,
    parameter int unsigned           LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] POLY       = DEFAULT_POLY,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 16'h0001
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 adv_i,
    input  logic                 mode_i,
    input  logic [OUT_WIDTH-1:0] max_value_i,
    input  logic                 ack_i,
    output logic [OUT_WIDTH-1:0] rand_o,
    output logic                 valid_o,
    output logic                 overrun_o
);

    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [OUT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  mode_q, mode_d;
    logic [OUT_WIDTH-1:0]  max_q, max_d;
    logic [OUT_WIDTH-1:0]  rand_q, rand_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic [OUT_WIDTH-1:0]  new_val_s;

    // A zero state can only come from corruption; reseed rather than stay locked up.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        if (s == '0) begin
            return SEED;
        end else if (s[0]) begin
            return (s >> 1) ^ POLY;
        end else begin
            return s >> 1;
        end
    endfunction

    // Generator state advance; only the selected generator moves, mode/bound are sampled here.
    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        max_d  = max_q;
        pend_d = adv_i;
        if (adv_i) begin
            mode_d = mode_i;
            max_d  = max_value_i;
            if (mode_i == MODE_LFSR) begin
                lfsr_d = lfsr_next(lfsr_q);
            end else if (max_value_i == '0) begin
                cnt_d = cnt_q + OUT_WIDTH'(1);
            end else if (cnt_q >= max_value_i - OUT_WIDTH'(1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + OUT_WIDTH'(1);
            end
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Scale the low LFSR bits into [0, max) with a full-width product.
    always_comb begin
        new_val_s = cnt_q;
        if (mode_q == MODE_LFSR) begin
            if (max_q == '0) begin
                new_val_s = lfsr_q[OUT_WIDTH-1:0];
            end else begin
                new_val_s = OUT_WIDTH'(({{OUT_WIDTH{1'b0}}, lfsr_q[OUT_WIDTH-1:0]} *
                                        {{OUT_WIDTH{1'b0}}, max_q}) >> OUT_WIDTH);
            end
        end else begin
            new_val_s = cnt_q;
        end
    end

    // Output handshake: a landing value beats a simultaneous ack.
    always_comb begin
        rand_d    = rand_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (pend_q) begin
            rand_d  = new_val_s;
            valid_d = 1'b1;
            if (valid_q && !ack_i) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (ack_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q    <= SEED;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            mode_q    <= MODE_COUNT;
            max_q     <= '0;
            rand_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            mode_q    <= mode_d;
            max_q     <= max_d;
            rand_q    <= rand_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rand_o    = rand_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/random_number_gen.sv
// Multi-channel pseudo-random value source: shared prescaler, step/tick advance,
// and packing of the per-channel outputs.
module random_number_gen
    import random_pkg::*;
#(
    parameter int unsigned           OUT_WIDTH  = 9,
    parameter int unsigned           LFSR_WIDTH = 16,
    parameter int unsigned           NUM_CH     = 2,
    parameter int unsigned           TICK_DIV   = 200000,
    parameter logic [LFSR_WIDTH-1:0] POLY       = DEFAULT_POLY,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 16'h0001
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        mode,
    input  logic                        step,
    input  logic [OUT_WIDTH-1:0]        max_value,
    output logic [NUM_CH*OUT_WIDTH-1:0] rand_out,
    output logic [NUM_CH-1:0]           valid,
    input  logic [NUM_CH-1:0]           ack,
    output logic [NUM_CH-1:0]           overrun
);

    localparam int unsigned           CNT_W     = $clog2(TICK_DIV);
    localparam logic [LFSR_WIDTH-1:0] BASE_SEED = (SEED == '0) ? LFSR_WIDTH'(1) : SEED;

    logic [CNT_W-1:0] pre_q, pre_d;
    logic             tick_s;
    logic             adv_s;

    // Prescaler; dropping enable clears it and swallows a tick due this cycle.
    always_comb begin
        tick_s = 1'b0;
        pre_d  = pre_q;
        if (!enable) begin
            pre_d = '0;
        end else if (pre_q == CNT_W'(TICK_DIV - 1)) begin
            tick_s = 1'b1;
            pre_d  = '0;
        end else begin
            pre_d = pre_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign adv_s = tick_s | step;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [LFSR_WIDTH-1:0] RAW_SEED =
            LFSR_WIDTH'(channel_seed(64'(BASE_SEED), k));
        localparam logic [LFSR_WIDTH-1:0] CH_SEED =
            (RAW_SEED == '0) ? LFSR_WIDTH'(1) : RAW_SEED;

        lfsr_channel #(
            .OUT_WIDTH  (OUT_WIDTH),
            .LFSR_WIDTH (LFSR_WIDTH),
            .POLY       (POLY),
            .SEED       (CH_SEED)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (reset_n),
            .adv_i       (adv_s),
            .mode_i      (mode),
            .max_value_i (max_value),
            .ack_i       (ack[k]),
            .rand_o      (rand_out[k*OUT_WIDTH +: OUT_WIDTH]),
            .valid_o     (valid[k]),
            .overrun_o   (overrun[k])
        );
    end

endmodule

// File: tb/tb_random_number_gen.sv
// Directed tables plus randomized traffic checked against a behavioural model.
module tb_random_number_gen;

    localparam int unsigned W  = 9;
    localparam int unsigned NC = 2;
    localparam int unsigned TD = 4;

    logic            clk;
    logic            reset_n;
    logic            enable;
    logic            mode;
    logic            step;
    logic [W-1:0]    max_value;
    logic [NC*W-1:0] rand_out;
    logic [NC-1:0]   valid;
    logic [NC-1:0]   ack;
    logic [NC-1:0]   overrun;

    int vectors;
    int miscompares;

    random_number_gen #(
        .OUT_WIDTH(W), .LFSR_WIDTH(16), .NUM_CH(NC), .TICK_DIV(TD),
        .POLY(16'hB400), .SEED(16'h0001)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .step(step),
        .max_value(max_value), .rand_out(rand_out), .valid(valid), .ack(ack),
        .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural reference model ----------------
    int unsigned m_lfsr [NC];
    int unsigned m_cnt  [NC];
    int unsigned m_out  [NC];
    int unsigned m_pval [NC];
    bit          m_valid[NC];
    bit          m_ovr  [NC];
    bit          m_pend;
    int unsigned m_cycles;

    function automatic int unsigned m_seed(int k);
        int unsigned s;
        s = (32'd1 ^ (k * 32'h9E37)) % 65536;
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int unsigned m_lfsr_next(int unsigned s, int k);
        if (s == 0) return m_seed(k);
        if (s % 2 == 1) return (s / 2) ^ 32'hB400;
        return s / 2;
    endfunction

    function automatic int unsigned m_reduce(int unsigned s, int unsigned mx);
        int unsigned r;
        r = s % 512;
        if (mx == 0) return r;
        return (r * mx) / 512;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_lfsr[k] = m_seed(k); m_cnt[k] = 0; m_out[k] = 0;
            m_pval[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
        end
        m_pend = 0; m_cycles = 0;
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_step();
        bit tick;
        bit adv;
        int unsigned limit;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NC; k++) begin
            if (m_pend) begin
                if (m_valid[k] && !ack[k]) m_ovr[k] = 1;
                m_valid[k] = 1;
                m_out[k]   = m_pval[k];
            end else if (ack[k]) begin
                m_valid[k] = 0;
            end
        end
        tick = 0;
        if (!enable) begin
            m_cycles = 0;
        end else begin
            m_cycles = m_cycles + 1;
            if (m_cycles == TD) begin
                tick = 1;
                m_cycles = 0;
            end
        end
        adv = tick | step;
        m_pend = adv;
        if (adv) begin
            for (int k = 0; k < NC; k++) begin
                if (mode) begin
                    m_lfsr[k] = m_lfsr_next(m_lfsr[k], k);
                    m_pval[k] = m_reduce(m_lfsr[k], max_value);
                end else begin
                    limit = (max_value == 0) ? 512 : max_value;
                    m_cnt[k] = (m_cnt[k] + 1 >= limit) ? 0 : m_cnt[k] + 1;
                    m_pval[k] = m_cnt[k];
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [NC*W-1:0] e_rand;
        logic [NC-1:0]   e_valid;
        logic [NC-1:0]   e_ovr;
        for (int k = 0; k < NC; k++) begin
            e_rand[k*W +: W] = W'(m_out[k]);
            e_valid[k]       = m_valid[k];
            e_ovr[k]         = m_ovr[k];
        end
        check("model", {10'd0, rand_out, valid, overrun}, {10'd0, e_rand, e_valid, e_ovr});
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset(input logic en);
        reset_n = 1'b0; enable = en; step = 1'b0; ack = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_state", {10'd0, rand_out, valid, overrun}, 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic step_once();
        step = 1'b1;
        clk_cycle();
        step = 1'b0;
        clk_cycle();
    endtask

    typedef struct {
        bit          rst;
        bit          md;
        int unsigned mx;
        int unsigned exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        vectors = 0; miscompares = 0;
        reset_n = 1'b0; enable = 1'b0; mode = 1'b1; step = 1'b0; max_value = '0; ack = '0;
        #2;

        tbl[0]  = '{1'b1, 1'b1, 0, 0};   tbl[1]  = '{1'b0, 1'b1, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 0, 256}; tbl[3]  = '{1'b1, 1'b1, 10, 0};
        tbl[4]  = '{1'b0, 1'b1, 10, 0};  tbl[5]  = '{1'b0, 1'b1, 10, 5};
        tbl[6]  = '{1'b1, 1'b0, 3, 1};   tbl[7]  = '{1'b0, 1'b0, 3, 2};
        tbl[8]  = '{1'b0, 1'b0, 3, 0};   tbl[9]  = '{1'b0, 1'b0, 3, 1};
        tbl[10] = '{1'b0, 1'b0, 3, 2};   tbl[11] = '{1'b0, 1'b0, 3, 0};
        tbl[12] = '{1'b0, 1'b0, 3, 1};   tbl[13] = '{1'b0, 1'b0, 1, 0};

        // Reset and first tick: valid rises on edge TD+1 with ch0=0 (B400), ch1=0x11B (4F1B).
        mode = 1'b1; max_value = '0;
        do_reset(1'b1);
        for (int i = 1; i <= TD; i++) begin
            clk_cycle();
            check("pre_tick_valid", {30'd0, valid}, 32'd0);
        end
        clk_cycle();
        check("first_tick_valid", {30'd0, valid}, 32'd3);
        check("first_tick_ch0", {23'd0, rand_out[W-1:0]}, 32'd0);
        check("first_tick_ch1", {23'd0, rand_out[2*W-1:W]}, 32'd283);

        // LFSR sequence, reduction and COUNT wrap from the table.
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset(1'b0);
            mode = tbl[i].md;
            max_value = W'(tbl[i].mx);
            step_once();
            check("table_ch0", {23'd0, rand_out[W-1:0]}, tbl[i].exp);
        end

        // Two unacked advances set overrun on both channels.
        mode = 1'b1; max_value = '0;
        do_reset(1'b0);
        step = 1'b1; clk_cycle(); clk_cycle();
        step = 1'b0; clk_cycle();
        check("overrun_set", {30'd0, overrun}, 32'd3);

        // Ack coinciding with a landing value: new value wins, no overrun.
        do_reset(1'b0);
        step_once();
        step = 1'b1; clk_cycle();
        step = 1'b0; ack = 2'b11; clk_cycle();
        check("ack_land_valid", {30'd0, valid}, 32'd3);
        check("ack_land_ovr", {30'd0, overrun}, 32'd0);
        clk_cycle();
        ack = 2'b00;
        check("ack_clears", {30'd0, valid}, 32'd0);

        // Step coinciding with tick gives exactly one advance.
        do_reset(1'b1);
        for (int i = 1; i <= TD; i++) begin
            step = (i == TD);
            clk_cycle();
        end
        step = 1'b0; enable = 1'b0;
        clk_cycle();
        check("coincide_ch0", {23'd0, rand_out[W-1:0]}, 32'd0);
        step_once();
        check("coincide_next1", {23'd0, rand_out[W-1:0]}, 32'd0);
        step_once();
        check("coincide_next2", {23'd0, rand_out[W-1:0]}, 32'd256);

        // Reset one cycle after an advance flushes the pipeline and restarts at B400.
        do_reset(1'b0);
        step_once();
        step_once();
        step = 1'b1; clk_cycle(); step = 1'b0;
        reset_n = 1'b0;
        clk_cycle();
        reset_n = 1'b1;
        check("midreset_valid", {30'd0, valid}, 32'd0);
        check("midreset_rand", {14'd0, rand_out}, 32'd0);
        step_once();
        check("restart_1", {23'd0, rand_out[W-1:0]}, 32'd0);
        step_once();
        check("restart_2", {23'd0, rand_out[W-1:0]}, 32'd0);
        step_once();
        check("restart_3", {23'd0, rand_out[W-1:0]}, 32'd256);

        // Randomized traffic against the model.
        do_reset(1'b1);
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            step   = ($urandom_range(0, 2) == 0);
            ack    = NC'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) mode = ~mode;
            if ($urandom_range(0, 15) == 0)
                max_value = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 5))
                                                        : W'($urandom_range(0, 511));
            reset_n = ($urandom_range(0, 400) != 0);
            clk_cycle();
            reset_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/random_number_gen.md
# random_number_gen

Multi-channel, parametrised pseudo-random value source for the game logic, such as spawn positions and shot timing. It replaces the single counter-based generator. Each channel holds its own Galois LFSR, or a legacy wrap-around counter when selected by mode. A shared prescaler paces updates, and a software step input forces an extra update. Each channel's result is range-reduced to [0, max_value) and presented with a valid/ack handshake and a sticky overrun flag.

## Interface
- `OUT_WIDTH`, default 9: width of each channel's output value.
- `LFSR_WIDTH`, default 16: LFSR state width; must be >= `OUT_WIDTH`.
- `NUM_CH`, default 2: number of independent channels.
- `TICK_DIV`, default 200000: prescaler period in clk cycles; must be >= 2.
- `POLY`, default 16'hB400: Galois feedback mask, right-shift form.
- `SEED`, default 16'h0001: base seed; a value of 0 is replaced by 1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  1 = prescaler runs; 0 = prescaler held at 0 and no ticks occur.
- `mode`  in  1  0 = COUNT (legacy wrap counter), 1 = LFSR.
- `step`  in  1  single-cycle request for an immediate update; works regardless of `enable`.
- `max_value`  in  OUT_WIDTH  exclusive upper bound shared by all channels; 0 = full range.
- `rand_out`  out  NUM_CH*OUT_WIDTH  channel k occupies bits [k*OUT_WIDTH +: OUT_WIDTH].
- `valid`  out  NUM_CH  per-channel "new value available" flag.
- `ack`  in  NUM_CH  per-channel consume; clears `valid`.
- `overrun`  out  NUM_CH  sticky flag: a value was overwritten before it was acked.

## Operation
- **Prescaler**
  - Counts 0..TICK_DIV-1 while `enable`=1.
  - `tick` is asserted in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
- **Advance event**: `adv = tick | step`. When `tick` and `step` are both high, exactly one advance occurs.
- **On `adv`, every channel updates in parallel.**
  - LFSR mode: `lsb = s[0]; s = s >> 1; if (lsb) s ^= POLY`.
  - COUNT mode: if `j >= max_value-1`, then `j = 0`; otherwise `j = j+1`.
    - `max_value` = 0 means wrap at 2^OUT_WIDTH.
    - The `>=` comparison means lowering `max_value` below the current `j` resets the counter on the next advance.
- **Seeds**
  - Channel k LFSR seed = `SEED ^ (k * 16'h9E37)`, truncated to LFSR_WIDTH bits.
  - An all-zero seed is replaced by 1.
  - Counters reset to 0.
- **LFSR lockup guard**: if the LFSR state is ever zero, the next advance loads the seed instead of shifting.
- **Range reduction (LFSR mode only)**
  - `r = s[OUT_WIDTH-1:0]`.
  - Output = `(r * max_value) >> OUT_WIDTH`, computed at full 2*OUT_WIDTH width.
  - `max_value` = 0: output = `r`.
  - COUNT mode outputs `j` directly.
- **Output stage**
  - The reduced value is registered into `rand_out` one cycle after `adv`, and `valid` is set in that same cycle.
- **Handshake**
  - `ack[k]` with `valid[k]`=1 clears `valid[k]` on the next edge.
  - If a new value lands while `valid[k]`=1 and `ack[k]`=0, the value is overwritten and `overrun[k]` is set.
  - If a new value lands in the same cycle as `ack[k]`, the new value wins: `valid` stays 1 and there is no overrun.
  - `ack` while `valid`=0 is ignored.
  - `overrun` clears only on reset.
- **Sampling of inputs**
  - `mode` and `max_value` are sampled at `adv`. A change between advances affects only the next value.
  - Switching mode does not disturb the state of the other generator.

## Timing
- **Reset (`reset_n` low, at any time)**
  - Prescaler = 0, LFSRs = seeds, counters = 0.
  - `rand_out` = 0, `valid` = 0, `overrun` = 0.
  - The output pipeline is flushed, so an in-flight value is lost.
- **First tick**: asserted on the TICK_DIV-th rising edge after reset release with `enable`=1; thereafter one tick every TICK_DIV cycles.
- **Latency**
  - `adv` at edge N: generator state updates at edge N.
  - `rand_out` and `valid` update at edge N+1.
- **Back-to-back `step` pulses**: one value per cycle (full throughput). Each overwrite of an unacked value sets `overrun`.
- **`enable` deasserted**: the prescaler clears immediately, and a pending tick in that cycle is suppressed.

## Structure
- **Package `random_pkg`**
  - Mode constants: `MODE_COUNT` = 1'b0, `MODE_LFSR` = 1'b1.
  - Default `POLY`.
  - Seed spread constant 16'h9E37.
- **Sub-module `lfsr_channel`**: one per channel, generated NUM_CH times. Contains:
  - the LFSR and counter state;
  - the reduction multiplier;
  - the output register, `valid`, and `overrun`.
- **Top level** contains only the prescaler, the `adv` logic, and the output bus packing.

## Test plan
All scenarios use TICK_DIV=4, NUM_CH=2, OUT_WIDTH=9, LFSR_WIDTH=16, POLY=16'hB400, SEED=1.
- **Reset and first tick**: release reset with `enable`=1, `mode`=LFSR, `max_value`=0 → `valid`=0 until edge 5; then ch0 = 0 (state B400).
- **LFSR sequence and reduction**
  - Three advances with `max_value`=0 → ch0 outputs 0, 0, 256 (states B400, 5A00, 2D00).
  - Repeat with `max_value`=10 → third output = 5.
- **COUNT mode wrap**: `max_value`=3 with seven `step` pulses → outputs 1, 2, 0, 1, 2, 0, 1. Lower `max_value` to 1 while `j`=1 → next output = 0.
- **Handshake**
  - No ack across two advances → `overrun` = 2'b11.
  - `ack` on the same cycle a new value lands → `valid` stays 1 and `overrun` stays 0.
- **Step coinciding with tick**: `step` in the same cycle as `tick` → exactly one LFSR advance.
- **Reset mid-operation**: reset pulse one cycle after `adv` → `valid` = 0, `rand_out` = 0, and the sequence restarts at B400.
